// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter
//   Shares the register file's single write port between two writeback sources.
//   Source A (main pipeline writeback) has fixed priority. Source B (mult/div unit)
//   is protected from starvation by an aging counter: once B has been stalled
//   STARVE_MAX cycles it is forced a grant and A stalls for that one cycle.
//   Accepted writes are driven to the regfile from registers one cycle later.
//
// Ports
//   clk, reset                 clock and synchronous active-high reset
//   a_valid/a_ready/a_addr/a_data   source A handshake and write payload
//   b_valid/b_ready/b_addr/b_data   source B handshake and write payload
//   we3, wa3, wd3              registered regfile write port
//   grant_src                  source of the current output cycle: 00 none, 01 A, 10 B
//   starve_cnt                 current aging count for B
module regfile_wr_arbiter #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned AW         = 5,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [AW-1:0]    a_addr,
    input  logic [WIDTH-1:0] a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [AW-1:0]    b_addr,
    input  logic [WIDTH-1:0] b_data,
    output logic             we3,
    output logic [AW-1:0]    wa3,
    output logic [WIDTH-1:0] wd3,
    output logic [1:0]       grant_src,
    output logic [3:0]       starve_cnt
);

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    logic             force_b;
    logic             a_fire;
    logic             b_fire;

    logic             we_q, we_d;
    logic [AW-1:0]    wa_q, wa_d;
    logic [WIDTH-1:0] wd_q, wd_d;
    logic [1:0]       gs_q, gs_d;
    logic [3:0]       cnt_q, cnt_d;

    assign force_b = b_valid && (cnt_q >= StarveMax);
    assign a_ready = !reset && !force_b;
    assign b_ready = !reset && (!a_valid || force_b);
    assign a_fire  = a_valid && a_ready;
    assign b_fire  = b_valid && b_ready;

    always_comb begin
        we_d  = 1'b0;
        wa_d  = wa_q;
        wd_d  = wd_q;
        gs_d  = 2'b00;
        cnt_d = cnt_q;

        // Ready rules make the two fires mutually exclusive.
        if (a_fire) begin
            we_d = (a_addr != '0);
            wa_d = a_addr;
            wd_d = a_data;
            gs_d = 2'b01;
        end else if (b_fire) begin
            we_d = (b_addr != '0);
            wa_d = b_addr;
            wd_d = b_data;
            gs_d = 2'b10;
        end

        if (b_valid && !b_ready) begin
            cnt_d = (cnt_q >= StarveMax) ? StarveMax : cnt_q + 4'd1;
        end else if (b_fire || !b_valid) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we_q  <= 1'b0;
            wa_q  <= '0;
            wd_q  <= '0;
            gs_q  <= 2'b00;
            cnt_q <= '0;
        end else begin
            we_q  <= we_d;
            wa_q  <= wa_d;
            wd_q  <= wd_d;
            gs_q  <= gs_d;
            cnt_q <= cnt_d;
        end
    end

    // A write still pending when reset arrives must not land on the reset edge.
    assign we3        = we_q && !reset;
    assign wa3        = wa_q;
    assign wd3        = wd_q;
    assign grant_src  = gs_q;
    assign starve_cnt = cnt_q;

endmodule
